// File: rtl/keccak_squeeze_out.sv
// Output stage of the Keccak permutation: catches the rising edge of the core's done level,
// snapshots the leading OUT_LANES lanes and streams them out one 64-bit lane per handshake.
module keccak_squeeze_out #(
    parameter int OUT_LANES = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          dout_vld_i,
    input  logic [1599:0] state_i,
    output logic [63:0]   lane_o,
    output logic          lane_vld_o,
    input  logic          lane_rdy_i,
    output logic          last_o,
    output logic          done_o,
    output logic          overrun_o
);

    localparam int               CNT_W    = (OUT_LANES > 1) ? $clog2(OUT_LANES) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(OUT_LANES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StSend,
        StDone
    } state_t;

    state_t                   r_state;
    logic                     r_vld_q;
    logic [CNT_W-1:0]         r_cnt;
    logic [64*OUT_LANES-1:0]  r_buf;
    logic                     r_overrun;

    logic w_rise;
    logic w_last;

    assign w_rise = dout_vld_i & ~r_vld_q;
    assign w_last = (r_cnt == LAST_IDX);

    // Every output is a decode of registered state or a slice of the buffer, so lane_rdy_i
    // never reaches lane_vld_o combinationally and lane_o/last_o hold while stalled.
    assign lane_vld_o = (r_state == StSend);
    assign last_o     = (r_state == StSend) & w_last;
    assign done_o     = (r_state == StDone);
    assign overrun_o  = r_overrun;
    assign lane_o     = r_buf[64*r_cnt +: 64];

    generate
        if (OUT_LANES < 25) begin : g_unused
            logic w_unused_state;
            assign w_unused_state = ^state_i[1599:64*OUT_LANES];
        end
    endgenerate

    // NOTE: all state here is updated with non-blocking assignments so every register samples
    // pre-edge values; blocking assignments would let later statements see half-updated state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= StIdle;
            r_vld_q   <= 1'b0;
            r_cnt     <= '0;
            r_overrun <= 1'b0;
            // NOTE: the lane buffer is reset deliberately because lane_o is defined to read 0
            // out of reset; a pure data store would normally be left unreset.
            r_buf     <= '0;
        end else begin
            r_vld_q <= dout_vld_i;
            case (r_state)
                StIdle: begin
                    if (w_rise) begin
                        r_buf   <= state_i[64*OUT_LANES-1:0];
                        r_cnt   <= '0;
                        r_state <= StSend;
                    end
                end
                StSend: begin
                    if (w_rise) r_overrun <= 1'b1;
                    if (lane_rdy_i) begin
                        if (w_last) begin
                            r_cnt   <= '0;
                            r_state <= StDone;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                StDone: begin
                    if (w_rise) r_overrun <= 1'b1;
                    r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule
